// File: rtl/arm_ex_stage.sv
// ARM execute stage: condition check, 16-op data-processing ALU, 4-cycle iterative MUL/MLA, EXMEM register.
// ALU results land in EXMEM one edge after issue; a multiply holds ex_stall for 3 cycles and lands on the 4th edge.
module arm_ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        IDEX_valid,
   input  logic [3:0]  IDEX_cond,
   input  logic [3:0]  IDEX_alu_op,
   input  logic        IDEX_set_flags,
   input  logic [31:0] IDEX_op1,
   input  logic [31:0] IDEX_op2,
   input  logic        IDEX_shifter_carry,
   input  logic        IDEX_is_mul,
   input  logic        IDEX_mul_acc,
   input  logic [31:0] IDEX_acc,
   input  logic [31:0] IDEX_rd_data,
   input  logic        IDEX_rd_we,
   input  logic        IDEX_rd_data_sel,
   input  logic        IDEX_ld_byte_or_word,
   input  logic        IDEX_internal_halted,
   input  logic [3:0]  IDEX_des_reg_num,
   input  logic [3:0]  IDEX_mem_write_en,
   output logic        ex_stall,
   output logic        EXID_rd_we,
   output logic [3:0]  EXID_rd_num,
   output logic [31:0] EXID_data_result,
   output logic [3:0]  cpsr_flags,
   output logic [31:0] EXMEM_data_result,
   output logic [31:0] EXMEM_rd_data,
   output logic        EXMEM_rd_we,
   output logic        EXMEM_rd_data_sel,
   output logic        EXMEM_ld_byte_or_word,
   output logic        EXMEM_internal_halted,
   output logic [3:0]  EXMEM_des_reg_num,
   output logic [3:0]  EXMEM_mem_write_en
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } mul_state_t;

   mul_state_t  r_state, w_state_nxt;
   logic [1:0]  r_cnt, w_cnt_nxt;
   logic [31:0] r_partial, w_partial_nxt;
   logic [3:0]  r_flags, w_flags_nxt;

   logic w_n, w_z, w_c, w_v;
   assign {w_n, w_z, w_c, w_v} = r_flags;

   logic w_cond_pass;
   always_comb begin
      w_cond_pass = 1'b0;
      case (IDEX_cond)
         4'h0:    w_cond_pass = w_z;
         4'h1:    w_cond_pass = !w_z;
         4'h2:    w_cond_pass = w_c;
         4'h3:    w_cond_pass = !w_c;
         4'h4:    w_cond_pass = w_n;
         4'h5:    w_cond_pass = !w_n;
         4'h6:    w_cond_pass = w_v;
         4'h7:    w_cond_pass = !w_v;
         4'h8:    w_cond_pass = w_c && !w_z;
         4'h9:    w_cond_pass = !w_c || w_z;
         4'hA:    w_cond_pass = (w_n == w_v);
         4'hB:    w_cond_pass = (w_n != w_v);
         4'hC:    w_cond_pass = !w_z && (w_n == w_v);
         4'hD:    w_cond_pass = w_z || (w_n != w_v);
         4'hE:    w_cond_pass = 1'b1;
         default: w_cond_pass = 1'b0;
      endcase
   end

   logic w_kill;
   assign w_kill = !IDEX_valid || !w_cond_pass;

   // Every arithmetic op maps onto a + b + cin; subtracts invert one operand so C is NOT borrow.
   logic [31:0] w_add_a, w_add_b, w_logic_res;
   logic        w_add_cin, w_arith;
   always_comb begin
      w_add_a     = IDEX_op1;
      w_add_b     = IDEX_op2;
      w_add_cin   = 1'b0;
      w_arith     = 1'b1;
      w_logic_res = '0;
      case (IDEX_alu_op)
         4'h2, 4'hA: begin
            w_add_b   = ~IDEX_op2;
            w_add_cin = 1'b1;
         end
         4'h3: begin
            w_add_a   = IDEX_op2;
            w_add_b   = ~IDEX_op1;
            w_add_cin = 1'b1;
         end
         4'h4, 4'hB: begin
            w_add_cin = 1'b0;
         end
         4'h5: begin
            w_add_cin = w_c;
         end
         4'h6: begin
            w_add_b   = ~IDEX_op2;
            w_add_cin = w_c;
         end
         4'h7: begin
            w_add_a   = IDEX_op2;
            w_add_b   = ~IDEX_op1;
            w_add_cin = w_c;
         end
         4'h0, 4'h8: begin
            w_arith     = 1'b0;
            w_logic_res = IDEX_op1 & IDEX_op2;
         end
         4'h1, 4'h9: begin
            w_arith     = 1'b0;
            w_logic_res = IDEX_op1 ^ IDEX_op2;
         end
         4'hC: begin
            w_arith     = 1'b0;
            w_logic_res = IDEX_op1 | IDEX_op2;
         end
         4'hD: begin
            w_arith     = 1'b0;
            w_logic_res = IDEX_op2;
         end
         4'hE: begin
            w_arith     = 1'b0;
            w_logic_res = IDEX_op1 & ~IDEX_op2;
         end
         default: begin
            w_arith     = 1'b0;
            w_logic_res = ~IDEX_op2;
         end
      endcase
   end

   logic [32:0] w_sum;
   logic [31:0] w_alu_res;
   logic        w_alu_c, w_alu_v, w_ovf, w_is_test;
   assign w_sum     = {1'b0, w_add_a} + {1'b0, w_add_b} + {32'd0, w_add_cin};
   assign w_ovf     = (w_add_a[31] == w_add_b[31]) && (w_sum[31] != w_add_a[31]);
   assign w_alu_res = w_arith ? w_sum[31:0] : w_logic_res;
   assign w_alu_c   = w_arith ? w_sum[32] : IDEX_shifter_carry;
   assign w_alu_v   = w_arith ? w_ovf : w_v;
   assign w_is_test = (IDEX_alu_op[3:2] == 2'b10);

   // One 32x8 partial product per cycle; r_cnt selects the op2 byte and its weight.
   logic [31:0] w_op2_sh, w_term, w_step, w_acc_init, w_mul_res;
   logic [4:0]  w_shamt;
   assign w_shamt    = {r_cnt, 3'b000};
   assign w_op2_sh   = IDEX_op2 >> w_shamt;
   assign w_term     = IDEX_op1 * {24'd0, w_op2_sh[7:0]};
   assign w_step     = w_term << w_shamt;
   assign w_acc_init = IDEX_mul_acc ? IDEX_acc : 32'd0;
   assign w_mul_res  = r_partial + w_step;

   logic w_mul_start, w_mul_done, w_stall;
   assign w_mul_start = (r_state == S_IDLE) && !w_kill && IDEX_is_mul;

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_partial_nxt = r_partial;
      w_stall       = 1'b0;
      w_mul_done    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_mul_start) begin
               w_state_nxt   = S_BUSY;
               w_cnt_nxt     = 2'd1;
               w_partial_nxt = w_acc_init + w_step;
               w_stall       = 1'b1;
            end
         end
         default: begin
            w_partial_nxt = w_mul_res;
            w_cnt_nxt     = r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
               w_state_nxt = S_IDLE;
               w_mul_done  = 1'b1;
            end else begin
               w_stall = 1'b1;
            end
         end
      endcase
   end

   logic        w_alu_wr, w_wr, w_rd_we;
   logic [31:0] w_result;
   assign w_alu_wr = (r_state == S_IDLE) && !w_kill && !IDEX_is_mul;
   assign w_wr     = w_alu_wr || w_mul_done;
   assign w_result = w_mul_done ? w_mul_res : w_alu_res;
   assign w_rd_we  = w_wr && IDEX_rd_we && !(w_alu_wr && w_is_test);

   // Multiplies touch only N and Z; C and V keep their previous values.
   always_comb begin
      w_flags_nxt = r_flags;
      if (w_alu_wr && (IDEX_set_flags || w_is_test)) begin
         w_flags_nxt = {w_alu_res[31], (w_alu_res == 32'd0), w_alu_c, w_alu_v};
      end else if (w_mul_done && IDEX_set_flags) begin
         w_flags_nxt = {w_mul_res[31], (w_mul_res == 32'd0), w_c, w_v};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 2'd0;
         r_partial <= 32'd0;
         r_flags   <= 4'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_partial <= w_partial_nxt;
         r_flags   <= w_flags_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         EXMEM_data_result     <= 32'd0;
         EXMEM_rd_data         <= 32'd0;
         EXMEM_rd_we           <= 1'b0;
         EXMEM_rd_data_sel     <= 1'b0;
         EXMEM_ld_byte_or_word <= 1'b0;
         EXMEM_internal_halted <= 1'b0;
         EXMEM_des_reg_num     <= 4'd0;
         EXMEM_mem_write_en    <= 4'd0;
      end else begin
         EXMEM_data_result     <= w_wr ? w_result : 32'd0;
         EXMEM_rd_data         <= IDEX_rd_data;
         EXMEM_rd_we           <= w_rd_we;
         EXMEM_rd_data_sel     <= IDEX_rd_data_sel;
         EXMEM_ld_byte_or_word <= IDEX_ld_byte_or_word;
         EXMEM_internal_halted <= IDEX_internal_halted;
         EXMEM_des_reg_num     <= IDEX_des_reg_num;
         EXMEM_mem_write_en    <= w_wr ? IDEX_mem_write_en : 4'd0;
      end
   end

   assign ex_stall         = w_stall;
   assign EXID_rd_we       = w_rd_we;
   assign EXID_rd_num      = IDEX_des_reg_num;
   assign EXID_data_result = w_result;
   assign cpsr_flags       = r_flags;

endmodule

// File: doc/arm_ex_stage.md
# arm_ex_stage

Execute stage of the 5-stage ARM pipeline, between the ID/EX register and the memory stage. It evaluates the condition code against the CPSR flags it holds and runs the 16 ARM data-processing ops on pre-shifted operands. It also runs MUL/MLA on an iterative 4-cycle multiplier that stalls upstream while busy. It registers the EXMEM_* bundle consumed by the memory stage and exposes an EX-side forwarding tap.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- IDEX_valid  in  1  ID/EX holds a real instruction (0 = bubble).
- IDEX_cond  in  4  ARM condition field.
- IDEX_alu_op  in  4  ARM DP opcode: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, A CMP, B CMN, C ORR, D MOV, E BIC, F MVN.
- IDEX_set_flags  in  1  S bit.
- IDEX_op1, IDEX_op2  in  32  Rn value; shifted operand 2.
- IDEX_shifter_carry  in  1  barrel-shifter carry-out.
- IDEX_is_mul, IDEX_mul_acc  in  1  MUL; MLA (accumulate IDEX_acc).
- IDEX_acc  in  32  accumulator for MLA.
- IDEX_rd_data  in  32  store data.
- IDEX_rd_we, IDEX_rd_data_sel, IDEX_ld_byte_or_word, IDEX_internal_halted  in  1  passed through.
- IDEX_des_reg_num  in  4; IDEX_mem_write_en  in  4  passed through.
- ex_stall  out  1  hold ID/EX and earlier stages this cycle.
- EXID_rd_we  out  1; EXID_rd_num  out  4; EXID_data_result  out  32  combinational forwarding tap of the result being computed.
- cpsr_flags  out  4  {N,Z,C,V}.
- EXMEM_data_result, EXMEM_rd_data  out  32; EXMEM_rd_we, EXMEM_rd_data_sel, EXMEM_ld_byte_or_word, EXMEM_internal_halted  out  1; EXMEM_des_reg_num, EXMEM_mem_write_en  out  4  registered outputs.

## Operation
- Condition pass uses standard ARM encoding (EQ..AL, NV=fail) against the current flags register.
- "Kill" = !IDEX_valid or condition fail. A kill emits a bubble into EXMEM: rd_we=0, mem_write_en=0, flags unchanged. internal_halted still propagates.
- ALU: 32-bit sum with carry. SUB-type ops are computed as op1 + ~op2 + 1, so C = NOT borrow. ADC/SBC/RSC use flag C. V = signed overflow of the add/sub.
- Logical ops (AND EOR TST TEQ ORR MOV BIC MVN): C = IDEX_shifter_carry; V unchanged.
- TST/TEQ/CMP/CMN force EXMEM_rd_we=0 and always update flags.
- Other ops update flags only when set_flags=1.
- N = result[31], Z = (result==0).
- Multiplier FSM states IDLE and BUSY, with a 2-bit cnt.
  - Start: IDLE with a non-killed IDEX_is_mul. Go to BUSY, cnt=1, partial = acc_init + op1*op2[7:0].
  - acc_init = IDEX_acc if mul_acc, else 0.
  - Each BUSY cycle adds (op1*op2[8cnt+7:8cnt]) << 8cnt, keeping the low 32 bits, then cnt++.
  - The cnt==3 cycle returns to IDLE and loads EXMEM with the final result.
- MUL with S: N and Z are updated; C and V are unchanged.
- ex_stall = (IDLE & mul start) | (BUSY & cnt!=3).
- While the multiplier is occupied, EXMEM receives bubbles except on the final cycle. IDEX inputs must stay stable during this time.
- EXID_rd_we is asserted only on the cycle the result is written into EXMEM.

## Timing
- Non-multiply ops: 1 cycle. Result is in EXMEM at the edge ending the cycle IDEX presents it.
- MUL/MLA accepted in cycle 0:
  - ex_stall is high in cycles 0–2 and low in cycle 3.
  - EXMEM gets bubbles at edges 0–2 and the product at edge 3. Flags update at edge 3.
  - Throughput is one multiply per 4 cycles. A back-to-back multiply starts in cycle 4.
- Reset (any cycle, including mid-multiply): FSM=IDLE, cnt=0, flags=0000, and every EXMEM_* output = 0, including internal_halted. ex_stall=0 in the cycle after reset.
- Flags written at edge N are visible to the condition check of the instruction in cycle N+1. There is no bypass within the same cycle.
- internal_halted arriving mid-multiply is sampled only on the final cycle, because IDEX is held stable.

## Test plan
- ADDS op1=0x7FFFFFFF, op2=1 → EXMEM_data_result=0x80000000, flags N=1 Z=0 C=0 V=1, rd_we as given.
- CMP 5,5, then ADDEQ 1+2 then ADDNE 1+2 → CMP gives rd_we=0 with flags Z=1 C=1. ADDEQ writes 3. ADDNE is a bubble (rd_we=0, mem_write_en=0).
- MLA op1=0x12345678, op2=0x9ABCDEF0, acc=1 → ex_stall high exactly 3 cycles; EXMEM shows 3 bubbles then 0x242D2081 (low 32 bits of product + 1).
- SBC with C=0, op1=10, op2=3 → 6, C=1. MVNS op2=0, shifter_carry=1 → 0xFFFFFFFF, N=1, C=1.
- rst asserted in cnt=2 of a MUL → next cycle all EXMEM_* = 0, ex_stall=0, flags=0. The following ADD completes in 1 cycle.
- IDEX_valid=0 with internal_halted=1 → EXMEM bubble with EXMEM_internal_halted=1.
